// File: rtl/sram_rw_port_adapter_if.sv
// Request, response and RW0 SRAM port bundle for sram_rw_port_adapter.
// The slave modport is the adapter side; the master modport is the client plus SRAM side.
interface sram_rw_port_adapter_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MASK_WIDTH = 4
);

  // Request stream
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [MASK_WIDTH-1:0] req_mask;
  logic [DATA_WIDTH-1:0] req_data;

  // Response stream
  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_write;
  logic [DATA_WIDTH-1:0] resp_data;

  // RW0 port of the attached array
  logic                  sram_en;
  logic                  sram_wmode;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [MASK_WIDTH-1:0] sram_wmask;
  logic [DATA_WIDTH-1:0] sram_wdata;
  logic [DATA_WIDTH-1:0] sram_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_mask, req_data,
    output req_ready,
    output resp_valid, resp_write, resp_data,
    input  resp_ready,
    output sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_mask, req_data,
    input  req_ready,
    input  resp_valid, resp_write, resp_data,
    output resp_ready,
    input  sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata,
    output sram_rdata
  );

endinterface

// File: rtl/sram_rw_port_adapter.sv
// Valid/ready front end for a single-port SRAM with 1-cycle read latency.
// Issued ops land in a 2-entry in-order response buffer guarded by a credit check.
module sram_rw_port_adapter #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MASK_WIDTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  sram_rw_port_adapter_if.slave      bus
);

  localparam int unsigned DEPTH   = 2;
  localparam int unsigned OCC_W   = 3;

  // Stage 1: op issued to the SRAM last cycle
  logic                  s1_vld;
  logic                  s1_wr;

  // Response buffer
  logic [DEPTH-1:0]                 fifo_wr;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] fifo_data;
  logic                             wr_ptr;
  logic                             rd_ptr;
  logic [1:0]                       count;

  logic             fire_c;
  logic             pop_c;
  logic             head_vld_c;
  logic [OCC_W-1:0] occupancy_c;

  // Occupancy after this edge, counting the op already in the SRAM pipe
  assign head_vld_c  = (count != 2'd0);
  assign pop_c       = head_vld_c & bus.resp_ready;
  assign occupancy_c = OCC_W'(count) + OCC_W'(s1_vld) - OCC_W'(pop_c);

  assign bus.req_ready = reset_n & (occupancy_c < OCC_W'(DEPTH));
  assign fire_c        = bus.req_valid & bus.req_ready;

  // RW0 strobes are a straight pass-through of the accepted request
  assign bus.sram_en    = fire_c;
  assign bus.sram_wmode = bus.req_write;
  assign bus.sram_addr  = ADDR_WIDTH'(bus.req_addr);
  assign bus.sram_wmask = bus.req_write ? MASK_WIDTH'(bus.req_mask) : '0;
  assign bus.sram_wdata = bus.req_data;

  // Head of buffer, masked to zero when empty so nothing stale leaks out
  assign bus.resp_valid = head_vld_c;
  assign bus.resp_write = head_vld_c & fifo_wr[rd_ptr];
  assign bus.resp_data  = head_vld_c ? fifo_data[rd_ptr] : '0;

  // Stage-1 tracking of the op whose read data appears next cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld <= 1'b0;
      s1_wr  <= 1'b0;
    end else begin
      s1_vld <= fire_c;
      s1_wr  <= fire_c & bus.req_write;
    end
  end

  // Response buffer: push captures sram_rdata while it is valid
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fifo_wr   <= '0;
      fifo_data <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      if (s1_vld) begin
        fifo_wr[wr_ptr]   <= s1_wr;
        fifo_data[wr_ptr] <= s1_wr ? '0 : DATA_WIDTH'(bus.sram_rdata);
        wr_ptr            <= ~wr_ptr;
      end
      if (pop_c) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= occupancy_c[1:0];
    end
  end

endmodule

// File: tb/tb_sram_rw_port_adapter.sv
// Directed bench for sram_rw_port_adapter with a behavioural 1-cycle-latency SRAM.
module tb_sram_rw_port_adapter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  sram_rw_port_adapter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) bus ();

  sram_rw_port_adapter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural SRAM: masked byte-lane writes, registered read data
  logic [DW-1:0] mem [0:15] = '{default: '0};
  always @(posedge clock) begin
    if (bus.sram_en) begin
      if (bus.sram_wmode) begin
        for (int l = 0; l < int'(MW); l++)
          if (bus.sram_wmask[l]) mem[bus.sram_addr[3:0]][l*8 +: 8] <= bus.sram_wdata[l*8 +: 8];
      end else begin
        bus.sram_rdata <= mem[bus.sram_addr[3:0]];
      end
    end
  end

  // Cycle counter and observation log of accepts and delivered responses
  typedef struct {
    int unsigned   cyc;
    logic          wr;
    logic [DW-1:0] data;
  } resp_t;

  int unsigned cyc = 0;
  resp_t       rq[$];
  int unsigned fire_cyc[$];
  resp_t       mon_r;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.resp_valid && bus.resp_ready) begin
        mon_r.cyc  = cyc;
        mon_r.wr   = bus.resp_write;
        mon_r.data = bus.resp_data;
        rq.push_back(mon_r);
      end
      if (bus.req_valid && bus.req_ready) fire_cyc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_log();
    rq.delete();
    fire_cyc.delete();
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
  endtask

  // Present one request from posedge+1 and return at posedge+1 after it is taken
  task automatic send(input logic wr, input int unsigned a, input logic [MW-1:0] m,
                      input logic [DW-1:0] d);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = AW'(a);
    bus.req_mask  = m;
    bus.req_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (bus.req_ready) begin
        @(posedge clock);
        #1;
        return;
      end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_resp(input int n);
    for (int i = 0; i < 60; i++) begin
      if (rq.size() >= n) break;
      tick(1);
    end
    tick(3);
  endtask

  task automatic test_reset();
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_mask   = '0;
    bus.req_data   = '0;
    bus.resp_ready = 1'b1;
    reset_n        = 1'b0;
    #3;
    vectors++; if (bus.resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
    vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
    vectors++; if (bus.sram_en !== 1'b0) begin miscompares++; $display("FAIL reset_sram_en: got %b want 0", bus.sram_en); end
    vectors++; if (bus.resp_data !== 32'h0) begin miscompares++; $display("FAIL reset_resp_data: got %h want 0", bus.resp_data); end
    tick(2);
    bus.req_valid = 1'b0;
    reset_n       = 1'b1;
    @(negedge clock);
    vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_req_ready: got %b want 1", bus.req_ready); end
    vectors++; if (bus.resp_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_resp_valid: got %b want 0", bus.resp_valid); end
    tick(1);
  endtask

  task automatic test_write_read();
    clear_log();
    send(1'b1, 5, 4'hF, 32'hDEAD_BEEF);
    send(1'b0, 5, 4'hF, 32'h0);
    idle();
    wait_resp(2);
    vectors++; if (rq.size() !== 2) begin miscompares++; $display("FAIL wr_rd_count: got %0d want 2", rq.size()); end
    if (rq.size() == 2 && fire_cyc.size() == 2) begin
      vectors++; if (rq[0].wr !== 1'b1 || rq[0].data !== 32'h0) begin miscompares++; $display("FAIL wr_ack: got wr=%b data=%h want wr=1 data=0", rq[0].wr, rq[0].data); end
      vectors++; if (rq[1].wr !== 1'b0 || rq[1].data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rd_data: got wr=%b data=%h want wr=0 data=deadbeef", rq[1].wr, rq[1].data); end
      vectors++; if (rq[0].cyc !== fire_cyc[0] + 2) begin miscompares++; $display("FAIL wr_latency: got cycle %0d want %0d", rq[0].cyc, fire_cyc[0] + 2); end
      vectors++; if (rq[1].cyc !== fire_cyc[1] + 2) begin miscompares++; $display("FAIL rd_latency: got cycle %0d want %0d", rq[1].cyc, fire_cyc[1] + 2); end
    end
  endtask

  task automatic test_masked_write();
    clear_log();
    send(1'b1, 7, 4'hF, 32'h1122_3344);
    send(1'b1, 7, 4'b0101, 32'hAABB_CCDD);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = AW'(7);
    bus.req_mask  = 4'hF;
    bus.req_data  = 32'hFFFF_FFFF;
    @(negedge clock);
    vectors++; if (bus.sram_en !== 1'b1) begin miscompares++; $display("FAIL rd_strobe_en: got %b want 1", bus.sram_en); end
    vectors++; if (bus.sram_wmode !== 1'b0) begin miscompares++; $display("FAIL rd_strobe_wmode: got %b want 0", bus.sram_wmode); end
    vectors++; if (bus.sram_wmask !== 4'h0) begin miscompares++; $display("FAIL rd_strobe_wmask: got %h want 0", bus.sram_wmask); end
    vectors++; if (bus.sram_addr !== 12'h007) begin miscompares++; $display("FAIL rd_strobe_addr: got %h want 007", bus.sram_addr); end
    tick(1);
    idle();
    wait_resp(3);
    vectors++; if (rq.size() !== 3) begin miscompares++; $display("FAIL mask_count: got %0d want 3", rq.size()); end
    if (rq.size() == 3) begin
      vectors++; if (rq[1].wr !== 1'b1) begin miscompares++; $display("FAIL mask_wr_ack: got %b want 1", rq[1].wr); end
      vectors++; if (rq[2].data !== 32'h11BB_33DD) begin miscompares++; $display("FAIL mask_rd_data: got %h want 11bb33dd", rq[2].data); end
    end
  endtask

  task automatic test_backpressure();
    int  idx;
    logic acc;
    for (int i = 0; i < 4; i++) send(1'b1, i, 4'hF, DW'(32'h100 + i));
    idle();
    wait_resp(4);
    clear_log();
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    idx = 0;
    repeat (8) begin
      @(negedge clock);
      acc = bus.req_ready;
      tick(1);
      if (acc) begin idx++; bus.req_addr = AW'(idx); end
    end
    @(negedge clock);
    vectors++; if (idx !== 2) begin miscompares++; $display("FAIL bp_accepted: got %0d want 2", idx); end
    vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_req_ready: got %b want 0", bus.req_ready); end
    vectors++; if (bus.resp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_resp_valid: got %b want 1", bus.resp_valid); end
    vectors++; if (rq.size() !== 0) begin miscompares++; $display("FAIL bp_no_pop: got %0d want 0", rq.size()); end
    tick(1);
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clock);
    vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_on_pop: got %b want 1", bus.req_ready); end
    tick(1);
    for (int i = idx; i < 4; i++) send(1'b0, i, 4'h0, 32'h0);
    idle();
    wait_resp(4);
    vectors++; if (rq.size() !== 4) begin miscompares++; $display("FAIL bp_count: got %0d want 4", rq.size()); end
    if (rq.size() == 4)
      for (int i = 0; i < 4; i++) begin
        vectors++; if (rq[i].data !== DW'(32'h100 + i) || rq[i].wr !== 1'b0) begin miscompares++; $display("FAIL bp_data[%0d]: got %h want %h", i, rq[i].data, 32'h100 + i); end
      end
  endtask

  task automatic test_back_to_back();
    clear_log();
    for (int i = 0; i < 16; i++) send(1'b1, i, 4'hF, DW'(32'h5A00_0000 | i));
    idle();
    wait_resp(16);
    clear_log();
    for (int i = 0; i < 16; i++) send(1'b0, i, 4'h0, 32'h0);
    idle();
    wait_resp(16);
    vectors++; if (rq.size() !== 16 || fire_cyc.size() !== 16) begin miscompares++; $display("FAIL b2b_count: got %0d resp %0d accepts want 16", rq.size(), fire_cyc.size()); end
    if (rq.size() == 16 && fire_cyc.size() == 16)
      for (int i = 0; i < 16; i++) begin
        vectors++; if (fire_cyc[i] !== fire_cyc[0] + i) begin miscompares++; $display("FAIL b2b_accept[%0d]: got cycle %0d want %0d", i, fire_cyc[i], fire_cyc[0] + i); end
        vectors++; if (rq[i].cyc !== fire_cyc[0] + 2 + i) begin miscompares++; $display("FAIL b2b_resp_cyc[%0d]: got %0d want %0d", i, rq[i].cyc, fire_cyc[0] + 2 + i); end
        vectors++; if (rq[i].data !== DW'(32'h5A00_0000 | i)) begin miscompares++; $display("FAIL b2b_data[%0d]: got %h want %h", i, rq[i].data, 32'h5A00_0000 | i); end
      end
  endtask

  task automatic test_rw_hazard();
    send(1'b1, 9, 4'hF, 32'h1);
    idle();
    wait_resp(1);
    clear_log();
    send(1'b0, 9, 4'h0, 32'h0);
    send(1'b1, 9, 4'hF, 32'h2);
    send(1'b0, 9, 4'h0, 32'h0);
    idle();
    wait_resp(3);
    vectors++; if (rq.size() !== 3) begin miscompares++; $display("FAIL haz_count: got %0d want 3", rq.size()); end
    if (rq.size() == 3) begin
      vectors++; if (rq[0].data !== 32'h1) begin miscompares++; $display("FAIL haz_old_data: got %h want 1", rq[0].data); end
      vectors++; if (rq[1].wr !== 1'b1) begin miscompares++; $display("FAIL haz_wr_ack: got %b want 1", rq[1].wr); end
      vectors++; if (rq[2].data !== 32'h2) begin miscompares++; $display("FAIL haz_new_data: got %h want 2", rq[2].data); end
    end
  endtask

  task automatic test_reset_in_flight();
    int   idx;
    logic acc;
    clear_log();
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    idx = 0;
    for (int c = 0; c < 10 && idx < 2; c++) begin
      @(negedge clock);
      acc = bus.req_ready;
      tick(1);
      if (acc) begin idx++; bus.req_addr = AW'(idx); end
    end
    vectors++; if (bus.resp_valid !== 1'b1) begin miscompares++; $display("FAIL rif_buffered: got %b want 1", bus.resp_valid); end
    reset_n = 1'b0;
    #1;
    vectors++; if (bus.resp_valid !== 1'b0) begin miscompares++; $display("FAIL rif_resp_valid: got %b want 0", bus.resp_valid); end
    vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL rif_req_ready: got %b want 0", bus.req_ready); end
    vectors++; if (bus.sram_en !== 1'b0) begin miscompares++; $display("FAIL rif_sram_en: got %b want 0", bus.sram_en); end
    vectors++; if (bus.resp_write !== 1'b0 || bus.resp_data !== 32'h0) begin miscompares++; $display("FAIL rif_resp_bus: got wr=%b data=%h want 0", bus.resp_write, bus.resp_data); end
    tick(2);
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    reset_n        = 1'b1;
    @(negedge clock);
    vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL rif_release_ready: got %b want 1", bus.req_ready); end
    tick(1);
    clear_log();
    tick(6);
    vectors++; if (rq.size() !== 0) begin miscompares++; $display("FAIL rif_stale: got %0d responses want 0", rq.size()); end
    send(1'b0, 1, 4'h0, 32'h0);
    idle();
    wait_resp(1);
    vectors++; if (rq.size() !== 1) begin miscompares++; $display("FAIL rif_after_count: got %0d want 1", rq.size()); end
    if (rq.size() == 1) begin
      vectors++; if (rq[0].data !== 32'h5A00_0001) begin miscompares++; $display("FAIL rif_after_data: got %h want 5a000001", rq[0].data); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_masked_write();
    test_backpressure();
    test_back_to_back();
    test_rw_hazard();
    test_reset_in_flight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
